// File: rtl/pn_dac_sigdta_mc.sv
// Multi-channel 1-bit sigma-delta DAC with selectable first/second-order
// modulators, a clock-divided modulator tick and a double-buffered sample input.
module pn_dac_sigdta_mc #(
  parameter int MSBI     = 16,
  parameter int CHANNELS = 2,
  parameter int CLKDIV   = 16,
  parameter int RATIO    = 128
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [CHANNELS*MSBI-1:0] DACin,
  input  logic                     DinValid,
  output logic                     DinReady,
  input  logic                     Order,
  input  logic                     Mute,
  input  logic                     ClrFlags,
  output logic [CHANNELS-1:0]      DACout,
  output logic                     SampleStrobe,
  output logic                     Underrun
);

  localparam int TW  = $clog2(CLKDIV);
  localparam int SCW = $clog2(RATIO);
  localparam int IW  = MSBI + 4;
  localparam int SW  = MSBI + 6;

  localparam logic signed [SW-1:0] ONE    = 1;
  localparam logic signed [SW-1:0] FS     = ONE <<< (MSBI - 1);
  localparam logic signed [SW-1:0] SAT_HI = (ONE <<< (MSBI + 2)) - ONE;
  localparam logic signed [SW-1:0] SAT_LO = -(ONE <<< (MSBI + 2));

  typedef enum logic {
    ORD_FIRST  = 1'b0,
    ORD_SECOND = 1'b1
  } order_e;

  logic [TW-1:0]              tick_cnt;
  logic [SCW-1:0]             samp_cnt;
  logic                       tick;
  logic                       boundary;
  logic [CHANNELS*MSBI-1:0]   active;
  logic [CHANNELS*MSBI-1:0]   pending;
  logic                       pending_full;
  order_e                     order_q;
  order_e                     order_nxt;
  logic                       order_clr;

  logic signed [IW-1:0]       i1     [CHANNELS];
  logic signed [IW-1:0]       i2     [CHANNELS];
  logic signed [IW-1:0]       i1_nxt [CHANNELS];
  logic signed [IW-1:0]       i2_nxt [CHANNELS];
  logic [CHANNELS-1:0]        dac_nxt;

  logic signed [SW-1:0]       x_s;
  logic signed [SW-1:0]       y_s;
  logic signed [SW-1:0]       a1;
  logic signed [SW-1:0]       a2;
  logic signed [SW-1:0]       s1;
  logic signed [SW-1:0]       s2;

  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[IW-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[IW-1:0];
    end
    return v[IW-1:0];
  endfunction

  assign tick     = (tick_cnt == TW'(CLKDIV - 1));
  assign boundary = tick && (samp_cnt == SCW'(RATIO - 1));
  assign DinReady = !pending_full;

  // A boundary tick already runs with the newly latched order; on an order
  // change that tick starts both integrators from zero.
  always_comb begin
    order_nxt = boundary ? order_e'(Order) : order_q;
    order_clr = boundary && (order_nxt != order_q);
    dac_nxt   = '0;
    x_s       = '0;
    y_s       = '0;
    a1        = '0;
    a2        = '0;
    s1        = '0;
    s2        = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      i1_nxt[k] = '0;
      i2_nxt[k] = '0;
    end
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      x_s       = Mute ? '0 : SW'($signed(active[k*MSBI +: MSBI]));
      y_s       = DACout[k] ? FS : -FS;
      a1        = order_clr ? '0 : SW'(i1[k]);
      a2        = order_clr ? '0 : SW'(i2[k]);
      s1        = a1 + x_s - y_s;
      i1_nxt[k] = sat(s1);
      s2        = a2 + SW'(i1_nxt[k]) - y_s;
      if (order_nxt == ORD_SECOND) begin
        i2_nxt[k]  = sat(s2);
        dac_nxt[k] = !i2_nxt[k][IW-1];
      end else begin
        i2_nxt[k]  = '0;
        dac_nxt[k] = !i1_nxt[k][IW-1];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tick_cnt     <= '0;
      samp_cnt     <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      order_q      <= ORD_FIRST;
      DACout       <= '0;
      SampleStrobe <= 1'b0;
      Underrun     <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        i1[k] <= '0;
        i2[k] <= '0;
      end
    end else begin
      tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
      SampleStrobe <= boundary;
      if (tick) begin
        samp_cnt <= boundary ? '0 : samp_cnt + 1'b1;
        DACout   <= dac_nxt;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          i1[k] <= i1_nxt[k];
          i2[k] <= i2_nxt[k];
        end
      end
      if (boundary) begin
        order_q <= order_nxt;
        if (pending_full) begin
          active       <= pending;
          pending_full <= 1'b0;
        end
      end
      // Accept uses the pre-edge buffer state, so a word arriving on an
      // empty-buffer boundary lands in pending and waits for the next one.
      if (DinValid && !pending_full) begin
        pending      <= DACin;
        pending_full <= 1'b1;
      end
      if (boundary && !pending_full) begin
        Underrun <= 1'b1;
      end else if (ClrFlags) begin
        Underrun <= 1'b0;
      end
    end
  end

endmodule
